// File: rtl/id_operand_stage.sv
// Decode-front operand stage between IF and EX: a DEPTH-entry {pc, inst} queue,
// rs/rt resolution with N-source priority forwarding, load-use interlock and a registered EX slot.
module id_operand_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int NFWD   = 2,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_inst,
    input  logic                   flush,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic                   wb_we,
    input  logic [4:0]             wb_waddr,
    input  logic [DATA_W-1:0]      wb_wdata,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [5*NFWD-1:0]      fwd_waddr,
    input  logic [DATA_W*NFWD-1:0] fwd_wdata,
    input  logic [NFWD-1:0]        fwd_is_load,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_inst,
    output logic [DATA_W-1:0]      out_src1,
    output logic [DATA_W-1:0]      out_src2,
    output logic                   stallreq,
    output logic [CNT_W-1:0]       stall_cycles
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Returns {hazard, value}. Older sources are applied first so the youngest match wins.
    function automatic logic [DATA_W:0] resolve_operand(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] rf_val
    );
        logic [DATA_W:0] res;
        if (wb_we && (wb_waddr == addr)) begin
            res = {1'b0, wb_wdata};
        end else begin
            res = {1'b0, rf_val};
        end
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == addr)) begin
                if (fwd_is_load[i]) begin
                    res = {1'b1, {DATA_W{1'b0}}};
                end else begin
                    res = {1'b0, fwd_wdata[DATA_W*i +: DATA_W]};
                end
            end
        end
        if (addr == 5'd0) begin
            res = {(DATA_W+1){1'b0}};
        end
        return res;
    endfunction

    logic [31:0]       pc_q   [DEPTH];
    logic [31:0]       inst_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_pc_q, out_pc_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [DATA_W-1:0] out_src1_q, out_src1_d;
    logic [DATA_W-1:0] out_src2_q, out_src2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              head_valid_s;
    logic [31:0]       head_pc_s;
    logic [31:0]       head_inst_s;
    logic [DATA_W:0]   res1_s, res2_s;
    logic              stall_s;
    logic              slot_free_s;
    logic              issue_s;
    logic              push_s;

    assign head_valid_s = (count_q != {(PTR_W+1){1'b0}});
    assign head_pc_s    = pc_q[rd_ptr_q];
    assign head_inst_s  = inst_q[rd_ptr_q];
    assign rf_raddr1    = head_inst_s[25:21];
    assign rf_raddr2    = head_inst_s[20:16];
    assign res1_s       = resolve_operand(rf_raddr1, rf_rdata1);
    assign res2_s       = resolve_operand(rf_raddr2, rf_rdata2);

    // Handshake decisions; in_ready deliberately depends only on registered occupancy.
    always_comb begin
        in_ready    = (count_q != FULL_CNT);
        stall_s     = head_valid_s & (res1_s[DATA_W] | res2_s[DATA_W]);
        slot_free_s = ~out_valid_q | out_ready;
        issue_s     = head_valid_s & ~stall_s & slot_free_s & ~flush;
        push_s      = in_valid & in_ready & ~flush;
    end

    // Queue pointer and occupancy next state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {(PTR_W+1){1'b0}};
        end else begin
            if (issue_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_s, issue_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Output slot and stall counter next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_src1_d  = out_src1_q;
        out_src2_d  = out_src2_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue_s) begin
            out_valid_d = 1'b1;
            out_pc_d    = head_pc_s;
            out_inst_d  = head_inst_s;
            out_src1_d  = res1_s[DATA_W-1:0];
            out_src2_d  = res2_s[DATA_W-1:0];
        end else if (slot_free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Queue storage, written at the tail on every accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= 32'd0;
                inst_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            pc_q[wr_ptr_q]   <= in_pc;
            inst_q[wr_ptr_q] <= in_inst;
        end
    end

    // Control and output-slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {(PTR_W+1){1'b0}};
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            out_inst_q  <= 32'd0;
            out_src1_q  <= {DATA_W{1'b0}};
            out_src2_q  <= {DATA_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_src1_q  <= out_src1_d;
            out_src2_q  <= out_src2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_inst     = out_inst_q;
    assign out_src1     = out_src1_q;
    assign out_src2     = out_src2_q;
    assign stallreq     = stall_s;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_id_operand_stage;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int NFWD   = 2;
    localparam int CNT_W  = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid, in_ready;
    logic [31:0]            in_pc, in_inst;
    logic                   flush;
    logic [4:0]             rf_raddr1, rf_raddr2;
    logic [DATA_W-1:0]      rf_rdata1, rf_rdata2;
    logic                   wb_we;
    logic [4:0]             wb_waddr;
    logic [DATA_W-1:0]      wb_wdata;
    logic [NFWD-1:0]        fwd_we;
    logic [5*NFWD-1:0]      fwd_waddr;
    logic [DATA_W*NFWD-1:0] fwd_wdata;
    logic [NFWD-1:0]        fwd_is_load;
    logic                   out_valid, out_ready;
    logic [31:0]            out_pc, out_inst;
    logic [DATA_W-1:0]      out_src1, out_src2;
    logic                   stallreq;
    logic [CNT_W-1:0]       stall_cycles;

    int checks = 0;
    int errors = 0;

    id_operand_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .fwd_is_load(fwd_is_load), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_src1(out_src1), .out_src2(out_src2),
        .stallreq(stallreq), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of fetched entries plus the EX slot contents.
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } entry_t;
    entry_t            mq[$];
    logic              m_valid;
    logic [31:0]       m_pc, m_inst;
    logic [DATA_W-1:0] m_s1, m_s2;
    logic [CNT_W-1:0]  m_stall;
    logic              e_stall, e_ready, e_issue, e_push;
    logic [4:0]        e_a1, e_a2;
    logic [DATA_W-1:0] e_v1, e_v2;

    function automatic void ref_operand(input logic [4:0] a, input logic [DATA_W-1:0] rf,
                                        output logic haz, output logic [DATA_W-1:0] v);
        haz = 1'b0;
        v   = rf;
        if (a == 5'd0) begin
            v = '0;
            return;
        end
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_we[i] && fwd_waddr[5*i +: 5] == a) begin
                haz = fwd_is_load[i];
                v   = haz ? '0 : fwd_wdata[DATA_W*i +: DATA_W];
                return;
            end
        end
        if (wb_we && wb_waddr == a) v = wb_wdata;
    endfunction

    task automatic model_eval();
        logic h1, h2;
        e_ready = (mq.size() != DEPTH);
        e_a1 = '0; e_a2 = '0; e_v1 = '0; e_v2 = '0; e_stall = 1'b0;
        if (mq.size() > 0) begin
            e_a1 = mq[0].inst[25:21];
            e_a2 = mq[0].inst[20:16];
            ref_operand(e_a1, rf_rdata1, h1, e_v1);
            ref_operand(e_a2, rf_rdata2, h2, e_v2);
            e_stall = h1 | h2;
        end
        e_issue = (mq.size() > 0) && !e_stall && (!m_valid || out_ready) && !flush;
        e_push  = in_valid && e_ready && !flush;
    endtask

    task automatic model_edge();
        entry_t e;
        if (e_stall && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
        if (flush) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            if (e_issue) begin
                m_valid = 1'b1;
                m_pc = mq[0].pc; m_inst = mq[0].inst; m_s1 = e_v1; m_s2 = e_v2;
                void'(mq.pop_front());
            end else if (!m_valid || out_ready) begin
                m_valid = 1'b0;
            end
            if (e_push) begin
                e.pc = in_pc; e.inst = in_inst;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_pc = '0; in_inst = '0; flush = 0; out_ready = 1;
        rf_rdata1 = '0; rf_rdata2 = '0; wb_we = 0; wb_waddr = '0; wb_wdata = '0;
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0; #1; rst = 1'b1;
        mq.delete(); m_valid = 0; m_pc = '0; m_inst = '0; m_s1 = '0; m_s2 = '0; m_stall = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0; #2; rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
        checks++; if ({out_pc, out_inst} !== 64'd0) begin errors++; $display("FAIL reset_out_pc_inst: got %h exp 0", {out_pc, out_inst}); end
        checks++; if ({out_src1, out_src2} !== 64'd0) begin errors++; $display("FAIL reset_out_src: got %h exp 0", {out_src1, out_src2}); end
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall_cycles: got %0d exp 0", stall_cycles); end
        checks++; if (in_ready !== 1'b1 || stallreq !== 1'b0) begin errors++; $display("FAIL reset_ready_stall: got %0b/%0b exp 1/0", in_ready, stallreq); end
        mq.delete(); m_valid = 0; m_stall = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_idle: got v=%0b r=%0b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rf_rdata1 = $urandom; rf_rdata2 = $urandom;
        in_valid = 1; in_pc = 32'hBFC00000; in_inst = 32'h3C010001;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency: got %0b exp 0", out_valid); end
        checks++; if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd1) begin errors++; $display("FAIL b2b_raddr0: got %0d/%0d exp 0/1", rf_raddr1, rf_raddr2); end
        in_pc = 32'hBFC00004; in_inst = 32'h34220005;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hBFC00000 || out_inst !== 32'h3C010001) begin
            errors++; $display("FAIL b2b_first: got v=%0b pc=%h inst=%h exp 1/bfc00000/3c010001", out_valid, out_pc, out_inst); end
        checks++; if (out_src1 !== 32'd0 || out_src2 !== rf_rdata2) begin errors++; $display("FAIL b2b_first_src: got %h/%h exp 0/%h", out_src1, out_src2, rf_rdata2); end
        checks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin errors++; $display("FAIL b2b_raddr1: got %0d/%0d exp 1/2", rf_raddr1, rf_raddr2); end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hBFC00004 || out_inst !== 32'h34220005) begin
            errors++; $display("FAIL b2b_second: got v=%0b pc=%h inst=%h exp 1/bfc00004/34220005", out_valid, out_pc, out_inst); end
        checks++; if (out_src1 !== rf_rdata1 || out_src2 !== rf_rdata2) begin errors++; $display("FAIL b2b_second_src: got %h/%h exp %h/%h", out_src1, out_src2, rf_rdata1, rf_rdata2); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b exp 0", out_valid); end
    endtask

    task automatic test_priority();
        logic [DATA_W-1:0] exp_v;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_pc = 32'h100 + 32'(k * 4); in_inst = 32'h00400020;
            fwd_we = '0; wb_we = 0;
            tick();
            in_valid = 0;
            fwd_we = (k == 0) ? 2'b11 : ((k == 1) ? 2'b10 : 2'b00);
            fwd_waddr = {5'd2, 5'd2}; fwd_wdata = {32'h22, 32'h11}; fwd_is_load = '0;
            wb_we = (k < 3); wb_waddr = 5'd2; wb_wdata = 32'h33;
            rf_rdata1 = $urandom;
            case (k)
                0: exp_v = 32'h11;
                1: exp_v = 32'h22;
                2: exp_v = 32'h33;
                default: exp_v = rf_rdata1;
            endcase
            tick();
            checks++; if (out_valid !== 1'b1 || out_src1 !== exp_v) begin
                errors++; $display("FAIL priority_%0d: got v=%0b src1=%h exp 1/%h", k, out_valid, out_src1, exp_v); end
        end
        fwd_we = '0; wb_we = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1; in_pc = 32'h200; in_inst = 32'h00030020;
        tick();
        in_valid = 0;
        fwd_we = 2'b11; fwd_waddr = {5'd3, 5'd3}; fwd_is_load = 2'b01; fwd_wdata = {32'h5555, 32'h0};
        #1;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %0b exp 1", stallreq); end
        tick();
        checks++; if (out_valid !== 1'b0 || stall_cycles !== 32'd1) begin
            errors++; $display("FAIL loaduse_hold: got v=%0b cnt=%0d exp 0/1", out_valid, stall_cycles); end
        fwd_we = 2'b10; fwd_is_load = 2'b00; fwd_wdata = {32'hABCD, 32'h0};
        #1;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL loaduse_release: got %0b exp 0", stallreq); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_src2 !== 32'hABCD || stall_cycles !== 32'd1) begin
            errors++; $display("FAIL loaduse_issue: got v=%0b src2=%h cnt=%0d exp 1/abcd/1", out_valid, out_src2, stall_cycles); end
        fwd_we = '0;
    endtask

    task automatic test_zero_src();
        do_reset();
        in_valid = 1; in_pc = 32'h300; in_inst = 32'h00000020;
        tick();
        in_valid = 0;
        fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd0}; fwd_is_load = 2'b01; fwd_wdata = {32'h0, 32'hFFFF};
        wb_we = 1; wb_waddr = 5'd0; wb_wdata = 32'h1234;
        rf_rdata1 = 32'hDEAD0001; rf_rdata2 = 32'hDEAD0002;
        #1;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL zero_nostall: got %0b exp 0", stallreq); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_src1 !== '0 || out_src2 !== '0) begin
            errors++; $display("FAIL zero_value: got v=%0b %h/%h exp 1/0/0", out_valid, out_src1, out_src2); end
        fwd_we = '0; fwd_is_load = '0; wb_we = 0;
    endtask

    task automatic test_backpressure();
        int seen;
        do_reset();
        out_ready = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1; in_pc = 32'h1000 + 32'(i * 4); in_inst = $urandom;
            #1; model_eval();
            checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL bp_in_ready_%0d: got %0b exp %0b", i, in_ready, e_ready); end
            tick();
        end
        in_valid = 0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h1000) begin
            errors++; $display("FAIL bp_full: got r=%0b v=%0b pc=%h exp 0/1/1000", in_ready, out_valid, out_pc); end
        tick();
        checks++; if (out_pc !== 32'h1000 || out_inst !== m_inst) begin errors++; $display("FAIL bp_stable: got %h/%h exp 1000/%h", out_pc, out_inst, m_inst); end
        out_ready = 1;
        seen = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick();
            if (out_valid) begin
                checks++; if (out_pc !== 32'h1000 + 32'((seen + 1) * 4)) begin
                    errors++; $display("FAIL bp_order_%0d: got %h exp %h", seen, out_pc, 32'h1000 + 32'((seen + 1) * 4)); end
                seen++;
            end
        end
        checks++; if (seen !== DEPTH) begin errors++; $display("FAIL bp_count: got %0d exp %0d", seen, DEPTH); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_pc = 32'h2000 + 32'(i * 4); in_inst = $urandom;
            tick();
        end
        flush = 1; out_ready = 1; in_valid = 1; in_pc = 32'h2F00; in_inst = $urandom;
        tick();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stallreq !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got v=%0b r=%0b s=%0b exp 0/1/0", out_valid, in_ready, stallreq); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got v=%0b pc=%h exp 0", out_valid, out_pc); end
        in_valid = 1; in_pc = 32'h2100; in_inst = 32'h00030020;
        fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd3}; fwd_is_load = 2'b01;
        tick();
        in_valid = 0;
        repeat (3) tick();
        checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL flush_cnt_pre: got %0d exp 3", stall_cycles); end
        #2; rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== '0 || out_src1 !== '0 || stall_cycles !== '0) begin
            errors++; $display("FAIL async_reset: got v=%0b pc=%h s1=%h cnt=%0d exp all 0", out_valid, out_pc, out_src1, stall_cycles); end
        checks++; if (in_ready !== 1'b1 || stallreq !== 1'b0) begin errors++; $display("FAIL async_reset_ctl: got %0b/%0b exp 1/0", in_ready, stallreq); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 25) == 0;
            in_pc = $urandom;
            in_inst = {6'h0, 5'($urandom % 4), 5'($urandom % 4), 16'($urandom)};
            fwd_we = 2'($urandom);
            fwd_waddr = {5'($urandom % 4), 5'($urandom % 4)};
            fwd_is_load = {(($urandom % 4) == 0), (($urandom % 4) == 0)};
            fwd_wdata = {32'($urandom), 32'($urandom)};
            wb_we = $urandom; wb_waddr = 5'($urandom % 4); wb_wdata = $urandom;
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            #1; model_eval();
            checks++; if (stallreq !== e_stall || in_ready !== e_ready) begin
                errors++; $display("FAIL rnd_ctl_%0d: got s=%0b r=%0b exp %0b/%0b", c, stallreq, in_ready, e_stall, e_ready); end
            if (mq.size() > 0) begin
                checks++; if (rf_raddr1 !== e_a1 || rf_raddr2 !== e_a2) begin
                    errors++; $display("FAIL rnd_raddr_%0d: got %0d/%0d exp %0d/%0d", c, rf_raddr1, rf_raddr2, e_a1, e_a2); end
            end
            tick();
            checks++; if (out_valid !== m_valid || stall_cycles !== m_stall) begin
                errors++; $display("FAIL rnd_valid_%0d: got v=%0b cnt=%0d exp %0b/%0d", c, out_valid, stall_cycles, m_valid, m_stall); end
            if (m_valid) begin
                checks++; if (out_pc !== m_pc || out_inst !== m_inst || out_src1 !== m_s1 || out_src2 !== m_s2) begin
                    errors++; $display("FAIL rnd_slot_%0d: got %h %h %h %h exp %h %h %h %h", c,
                        out_pc, out_inst, out_src1, out_src2, m_pc, m_inst, m_s1, m_s2); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_priority();
        test_load_use();
        test_zero_src();
        test_backpressure();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
